uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_tx_buf.sv | 153 +++++++++++++++
 tb/tb_uart_tx_buf.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buf.sv
// Byte FIFO feeding an 8N1 UART transmitter; bit period is latched from baud
// when a byte is popped, so a frame in flight never sees baud changes.
module uart_tx_buf #(
    parameter int DEPTH = 16
) (
    input  logic                     msoc_clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic [15:0]              baud,
    input  logic                     wrerr_clr,
    output logic                     tx,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wrerr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;
    logic          ovf;

    state_t        state, state_n;
    logic          tx_r, tx_n;
    logic [7:0]    sh, sh_n;
    logic [15:0]   bitlen, bitlen_n;
    logic [15:0]   bcnt, bcnt_n;
    logic [2:0]    bidx, bidx_n;

    assign full  = (cnt == CNT_FULL);
    assign empty = (cnt == '0);
    assign count = cnt;
    assign push  = wr_en & ~full;
    // An overflowing write is dropped even if a pop frees a slot on the same edge.
    assign ovf   = wr_en & full;
    assign tx    = tx_r;
    assign busy  = (state != IDLE);

    always_ff @(posedge msoc_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            wrerr  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            if (ovf) begin
                wrerr <= 1'b1;
            end else if (wrerr_clr) begin
                wrerr <= 1'b0;
            end
        end
    end

    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            tx_r   <= 1'b1;
            sh     <= '0;
            bitlen <= '0;
            bcnt   <= '0;
            bidx   <= '0;
        end else begin
            state  <= state_n;
            tx_r   <= tx_n;
            sh     <= sh_n;
            bitlen <= bitlen_n;
            bcnt   <= bcnt_n;
            bidx   <= bidx_n;
        end
    end

    always_comb begin
        state_n  = state;
        tx_n     = tx_r;
        sh_n     = sh;
        bitlen_n = bitlen;
        bcnt_n   = bcnt;
        bidx_n   = bidx;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    sh_n     = mem[rd_ptr];
                    bitlen_n = (baud == 16'd0) ? 16'd1 : baud;
                    bcnt_n   = bitlen_n - 16'd1;
                    tx_n     = 1'b0;
                    state_n  = START;
                end
            end
            START: begin
                if (bcnt == 16'd0) begin
                    state_n = DATA;
                    tx_n    = sh[0];
                    sh_n    = {1'b0, sh[7:1]};
                    bidx_n  = 3'd0;
                    bcnt_n  = bitlen - 16'd1;
                end else begin
                    bcnt_n = bcnt - 16'd1;
                end
            end
            DATA: begin
                if (bcnt == 16'd0) begin
                    bcnt_n = bitlen - 16'd1;
                    if (bidx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bidx_n = bidx + 3'd1;
                        tx_n   = sh[0];
                        sh_n   = {1'b0, sh[7:1]};
                    end
                end else begin
                    bcnt_n = bcnt - 16'd1;
                end
            end
            STOP: begin
                if (bcnt == 16'd0) begin
                    state_n = IDLE;
                end else begin
                    bcnt_n = bcnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed waveform points.
module tb_uart_tx_buf;

    localparam int DEPTH = 16;

    logic        msoc_clk = 1'b0;
    logic        rstn     = 1'b0;
    logic        wr_en    = 1'b0;
    logic [7:0]  wr_data  = 8'h00;
    logic [15:0] baud     = 16'd4;
    logic        wrerr_clr = 1'b0;
    logic        tx, busy, full, empty, wrerr;
    logic [4:0]  count;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_tx_buf #(.DEPTH(DEPTH)) dut (
        .msoc_clk (msoc_clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .baud     (baud),
        .wrerr_clr(wrerr_clr),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .wrerr    (wrerr)
    );

    always #5 msoc_clk = ~msoc_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: byte queue plus a per-cycle list of future line levels.
    byte unsigned mq[$];
    bit           ms[$];
    bit           m_wrerr = 1'b0;
    bit           m_idle, m_ovf, m_psh;
    byte unsigned m_b;
    int           m_bl;

    always @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            ms.delete();
            m_wrerr = 1'b0;
        end else begin
            m_idle = (ms.size() == 0);
            m_ovf  = wr_en && (mq.size() == DEPTH);
            m_psh  = wr_en && (mq.size() < DEPTH);
            if (!m_idle) begin
                void'(ms.pop_front());
            end else if (mq.size() > 0) begin
                m_b  = mq.pop_front();
                m_bl = (baud == 16'd0) ? 1 : int'(baud);
                for (int i = 0; i < m_bl; i++) ms.push_back(1'b0);
                for (int b = 0; b < 8; b++)
                    for (int i = 0; i < m_bl; i++) ms.push_back(m_b[b]);
                for (int i = 0; i < m_bl; i++) ms.push_back(1'b1);
            end
            if (m_psh) mq.push_back(wr_data);
            if (m_ovf) m_wrerr = 1'b1;
            else if (wrerr_clr) m_wrerr = 1'b0;
        end
    end

    always @(negedge msoc_clk) begin
        chk("m_tx",    tx,    (ms.size() != 0) ? ms[0] : 1'b1);
        chk("m_busy",  busy,  ms.size() != 0);
        chk("m_count", count, mq.size());
        chk("m_full",  full,  mq.size() == DEPTH);
        chk("m_empty", empty, mq.size() == 0);
        chk("m_wrerr", wrerr, m_wrerr);
    end

    task automatic tick();
        @(posedge msoc_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int k;
        k = 0;
        while (busy && k < maxc) begin
            tick();
            k++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog at %0t: got running expected finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] f55;
        f55 = {1'b1, 8'h55, 1'b0};

        ticks(2);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", count, 5'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_wrerr", wrerr, 1'b0);
        rstn = 1'b1;

        // 0x55 at 4 cycles per bit
        baud = 16'd4;
        wr(8'h55);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("f55_first", tx, f55[i]);
            chk("f55_busy", busy, 1'b1);
            ticks(3);
            chk("f55_last", tx, f55[i]);
            tick();
        end
        chk("f55_done_busy", busy, 1'b0);
        chk("f55_done_tx", tx, 1'b1);

        // back-to-back 0x01, 0x80 at 2 cycles per bit
        baud = 16'd2;
        wr_en = 1'b1; wr_data = 8'h01; tick();
        wr_data = 8'h80; tick();
        wr_en = 1'b0;
        chk("b2b_count", count, 5'd1);
        chk("b2b_tx_start", tx, 1'b0);
        ticks(17);
        chk("b2b_bit7", tx, 1'b0);
        tick(); chk("b2b_stop0", tx, 1'b1);
        tick(); chk("b2b_stop1", tx, 1'b1);
        tick(); chk("b2b_gap", tx, 1'b1); chk("b2b_gap_busy", busy, 1'b0);
        tick(); chk("b2b_start2", tx, 1'b0); chk("b2b_empty", empty, 1'b1);
        wait_idle(100);

        // fill to full, overflow, sticky flag
        baud = 16'd100;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i); tick();
        end
        wr_en = 1'b0;
        chk("fill_count", count, 5'd16);
        chk("fill_full", full, 1'b1);
        chk("fill_wrerr", wrerr, 1'b0);
        wr(8'hEE);
        chk("ovf_wrerr", wrerr, 1'b1);
        chk("ovf_count", count, 5'd16);
        wrerr_clr = 1'b1; tick(); wrerr_clr = 1'b0;
        chk("clr_wrerr", wrerr, 1'b0);
        wr_en = 1'b1; wrerr_clr = 1'b1; tick();
        wr_en = 1'b0; wrerr_clr = 1'b0;
        chk("ovf_beats_clr", wrerr, 1'b1);
        wrerr_clr = 1'b1; tick(); wrerr_clr = 1'b0;
        chk("clr2_wrerr", wrerr, 1'b0);
        wait_idle(1100);
        wr(8'hEF);
        chk("ovf_pop_count", count, 5'd15);
        chk("ovf_pop_wrerr", wrerr, 1'b1);
        chk("ovf_pop_busy", busy, 1'b1);
        rstn = 1'b0;
        #1;
        chk("rst1_count", count, 5'd0);
        chk("rst1_wrerr", wrerr, 1'b0);
        tick();
        rstn = 1'b1;

        // push and pop together at count 5
        baud = 16'd2;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i); tick();
        end
        wr_en = 1'b0;
        chk("pp_count_before", count, 5'd5);
        wait_idle(50);
        chk("pp_count_idle", count, 5'd5);
        wr(8'h3C);
        chk("pp_count_after", count, 5'd5);
        chk("pp_busy", busy, 1'b1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;

        // reset mid-DATA with 3 queued
        baud = 16'd4;
        wr_en = 1'b1; wr_data = 8'h00; tick();
        wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_data = 8'h33; tick();
        wr_en = 1'b0;
        chk("mid_count", count, 5'd3);
        ticks(10);
        chk("mid_busy", busy, 1'b1);
        chk("mid_tx", tx, 1'b0);
        rstn = 1'b0;
        #1;
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_count", count, 5'd0);
        chk("abort_empty", empty, 1'b1);
        tick();
        rstn = 1'b1;
        wr(8'hA5);
        tick(); chk("a5_start", tx, 1'b0);
        ticks(4); chk("a5_bit0", tx, 1'b1);
        ticks(4); chk("a5_bit1", tx, 1'b0);
        wait_idle(60);
        chk("a5_count", count, 5'd0);

        // baud=0 acts as 1; baud change mid-frame
        baud = 16'd0;
        wr(8'hFF);
        tick(); chk("b0_start", tx, 1'b0); chk("b0_busy", busy, 1'b1);
        tick(); chk("b0_bit0", tx, 1'b1);
        ticks(8); chk("b0_stop", tx, 1'b1); chk("b0_stop_busy", busy, 1'b1);
        tick(); chk("b0_done", busy, 1'b0);

        baud = 16'd3;
        wr_en = 1'b1; wr_data = 8'h0F; tick();
        wr_data = 8'hF0; tick();
        wr_en = 1'b0;
        baud = 16'd8;
        chk("bc_start", tx, 1'b0);
        ticks(3); chk("bc_bit0", tx, 1'b1);
        ticks(27); chk("bc_idle", busy, 1'b0);
        tick(); chk("bc2_start", tx, 1'b0);
        ticks(7); chk("bc2_start_end", tx, 1'b0);
        tick(); chk("bc2_bit0", tx, 1'b0);
        ticks(31); chk("bc2_bit3", tx, 1'b0);
        tick(); chk("bc2_bit4", tx, 1'b1);
        wait_idle(200);
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
